// File: rtl/soc_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : soc_ram_ctrl
// Purpose  : Two-port request/acknowledge front end for the single-port
//            on-chip SRAM. Port 0 serves instruction fetch, port 1 serves
//            data load/store. Arbitrates the ports, turns byte enables into
//            the SRAM's inverted bit mask (1 = keep old bit), sequences the
//            one-cycle registered read latency and returns a one-cycle ack.
// Options  : `define SOC_RAM_CTRL_RR_EN selects round-robin arbitration;
//            left undefined, port 0 has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module soc_ram_ctrl #(
    parameter int WORD_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int BE_WIDTH   = WORD_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  p0_req_i,
    input  logic                  p0_we_i,
    input  logic [ADDR_WIDTH-1:0] p0_addr_i,
    input  logic [BE_WIDTH-1:0]   p0_be_i,
    input  logic [WORD_WIDTH-1:0] p0_wdata_i,
    output logic                  p0_ack_o,
    output logic [WORD_WIDTH-1:0] p0_rdata_o,

    input  logic                  p1_req_i,
    input  logic                  p1_we_i,
    input  logic [ADDR_WIDTH-1:0] p1_addr_i,
    input  logic [BE_WIDTH-1:0]   p1_be_i,
    input  logic [WORD_WIDTH-1:0] p1_wdata_i,
    output logic                  p1_ack_o,
    output logic [WORD_WIDTH-1:0] p1_rdata_o,

    output logic                  ram_sel_o,
    output logic                  ram_read_o,
    output logic                  ram_write_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [WORD_WIDTH-1:0] ram_mask_o,
    output logic [WORD_WIDTH-1:0] ram_data_o,
    input  logic [WORD_WIDTH-1:0] ram_data_i
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] ACK     = 2'd3;

    logic [1:0]            state;
    logic                  grant_p1;   // port owning the access in flight
    logic                  acc_we;     // access in flight is a write
    logic                  req_any;
    logic                  pick_p1;    // arbitration result for this cycle
    logic                  pick_we;
    logic [ADDR_WIDTH-1:0] pick_addr;
    logic [BE_WIDTH-1:0]   pick_be;
    logic [WORD_WIDTH-1:0] pick_wdata;
    logic [WORD_WIDTH-1:0] pick_mask;

    assign req_any = p0_req_i | p1_req_i;

`ifdef SOC_RAM_CTRL_RR_EN
    // Remembers the winner of the last grant; reset value lets port 0 win a tie.
    logic last_p1;

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        pick_p1 = p1_req_i & (~p0_req_i | ~last_p1);
    end

    // Update the round-robin pointer whenever a grant is issued.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_p1 <= 1'b1;
        end else if (state == IDLE && req_any) begin
            last_p1 <= pick_p1;
        end
    end
`else
    // Fixed priority: port 1 wins only when port 0 is not requesting.
    always_comb begin
        pick_p1 = p1_req_i & ~p0_req_i;
    end
`endif

    // Mux the winning port's request fields.
    always_comb begin
        pick_we    = pick_p1 ? p1_we_i    : p0_we_i;
        pick_addr  = pick_p1 ? p1_addr_i  : p0_addr_i;
        pick_be    = pick_p1 ? p1_be_i    : p0_be_i;
        pick_wdata = pick_p1 ? p1_wdata_i : p0_wdata_i;
    end

    // A cleared byte enable keeps all eight bits of that byte in the SRAM.
    for (genvar k = 0; k < BE_WIDTH; k++) begin : g_mask
        assign pick_mask[8*k +: 8] = {8{~pick_be[k]}};
    end

    // Access sequencer: IDLE -> ACCESS -> CAPTURE -> ACK, all outputs registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            grant_p1    <= 1'b0;
            acc_we      <= 1'b0;
            ram_sel_o   <= 1'b0;
            ram_read_o  <= 1'b0;
            ram_write_o <= 1'b0;
            ram_addr_o  <= '0;
            ram_mask_o  <= '0;
            ram_data_o  <= '0;
            p0_ack_o    <= 1'b0;
            p1_ack_o    <= 1'b0;
            p0_rdata_o  <= '0;
            p1_rdata_o  <= '0;
        end else begin
            p0_ack_o <= 1'b0;
            p1_ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        grant_p1    <= pick_p1;
                        acc_we      <= pick_we;
                        ram_addr_o  <= pick_addr;
                        ram_mask_o  <= pick_mask;
                        ram_data_o  <= pick_wdata;
                        ram_sel_o   <= 1'b1;
                        ram_write_o <= pick_we;
                        ram_read_o  <= ~pick_we;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    // SRAM samples the strobes at the end of this cycle.
                    ram_sel_o   <= 1'b0;
                    ram_write_o <= 1'b0;
                    ram_read_o  <= 1'b0;
                    state       <= CAPTURE;
                end
                CAPTURE: begin
                    // Registered read data is valid now; writes leave rdata alone.
                    if (!acc_we) begin
                        if (grant_p1) begin
                            p1_rdata_o <= ram_data_i;
                        end else begin
                            p0_rdata_o <= ram_data_i;
                        end
                    end
                    if (grant_p1) begin
                        p1_ack_o <= 1'b1;
                    end else begin
                        p0_ack_o <= 1'b1;
                    end
                    state <= ACK;
                end
                ACK: begin
                    // No grant here, so a held request restarts on the next IDLE.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/soc_ram_ctrl.md
Name: soc_ram_ctrl

Overview:
- Two-port request/acknowledge front end for the single-port on-chip SRAM (soc_ram). Sits directly upstream of it.
- Port 0 is the instruction fetch path; port 1 is the data load/store path.
- Arbitrates between the two ports and converts per-byte enables into the SRAM's inverted bit mask (mask bit 1 = keep old bit).
- Sequences the SRAM's one-cycle registered read latency and returns captured read data with a one-cycle acknowledge.

Parameters:
- WORD_WIDTH, 16, data word width; must be a multiple of 8.
- ADDR_WIDTH, 8, word address width; equals the SRAM address width.
- BE_WIDTH, WORD_WIDTH/8, byte-enable width per port.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- p0_req_i  input  1  port 0 request; held high until p0_ack_o.
- p0_we_i  input  1  port 0: 1 = write, 0 = read.
- p0_addr_i  input  ADDR_WIDTH  port 0 word address.
- p0_be_i  input  BE_WIDTH  port 0 byte enables; bit k covers bits 8k+7:8k.
- p0_wdata_i  input  WORD_WIDTH  port 0 write data.
- p0_ack_o  output  1  port 0 one-cycle completion pulse.
- p0_rdata_o  output  WORD_WIDTH  port 0 last read data.
- p1_req_i, p1_we_i, p1_addr_i, p1_be_i, p1_wdata_i, p1_ack_o, p1_rdata_o: same as port 0, for port 1.
- ram_sel_o  output  1  SRAM select.
- ram_read_o  output  1  SRAM read strobe.
- ram_write_o  output  1  SRAM write strobe.
- ram_addr_o  output  ADDR_WIDTH  SRAM address.
- ram_mask_o  output  WORD_WIDTH  SRAM mask; 1 = preserve bit.
- ram_data_o  output  WORD_WIDTH  SRAM write data.
- ram_data_i  input  WORD_WIDTH  SRAM registered read data.

Behaviour:
- Clocking and reset: one clock (clk_i). rst_i is synchronous and active-high.
- Reset values:
  - State = IDLE; all outputs 0.
  - Both rdata registers 0; arbitration pointer favours port 0.
- Reset mid-operation: abandons any access and clears the acks; no ack is issued for it. A write strobe already sampled by the SRAM still lands, since the SRAM has no reset.
- FSM states: IDLE, ACCESS, CAPTURE, ACK. Only registers drive the outputs.
- IDLE:
  - If any req is high, grant one port, latch its we/addr/be/wdata into ram_* registers, go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS (1 cycle):
  - ram_sel_o = 1.
  - ram_write_o = we; ram_read_o = ~we.
  - Go to CAPTURE.
- CAPTURE (1 cycle):
  - Strobes return to 0.
  - On a read, ram_data_i is captured into the granted port's rdata register at the end of this cycle.
  - Go to ACK.
- ACK (1 cycle):
  - Granted port's ack_o = 1; rdata_o is valid for reads.
  - No new grant in this cycle.
  - Go to IDLE.
- Latency:
  - req sampled in IDLE at cycle N; ack_o high in cycle N+3.
  - A requester holding req high at N+4 starts a new access: 4 cycles per access.
- rdata_o holding rules:
  - Holds its value until the next read completes on the same port.
  - Writes never change rdata_o.
- Mask generation: ram_mask_o bits of byte k = ~be[k], replicated over 8 bits.
  - be = all-ones gives mask 0 (full write).
  - be = 0 on a write still runs the full cycle with mask all-ones (no change) and acks.
  - be is ignored on reads.
- Inactive-cycle values: ram_addr_o, ram_mask_o and ram_data_o hold their last values outside ACCESS.
- Arbitration with macro undefined: fixed priority, port 0 wins when both request.
- Simultaneous requests: the losing port keeps req high and is served in the next IDLE.
- Protocol violation: dropping req before ack has no effect; the access still completes and acks.

Optional Feature:
- SOC_RAM_CTRL_RR_EN:
  - Defined: round-robin arbitration. A one-bit pointer names the port that won the last grant; on a simultaneous request the other port wins. A single requester always wins.
  - Undefined: fixed priority to port 0; the pointer register is not built.

Test Plan:
- Single write then read:
  - Stimulus: p1 writes addr 0x12, be 2'b11, data 0xBEEF; then p1 reads addr 0x12.
  - Response: write ack at N+3; ram_write_o and ram_sel_o high for exactly one cycle with ram_mask_o 0x0000; read ack 4 cycles later with p1_rdata_o 0xBEEF.
- Byte write:
  - Stimulus: preload 0x1234; p0 writes be 2'b01, data 0xAACD.
  - Response: ram_mask_o 0xFF00; a later read returns 0x12CD.
- Simultaneous requests:
  - Stimulus: p0 reads addr 0x00 and p1 reads addr 0x01 in the same cycle.
  - Response: p0 acked at N+3 and p1 at N+7, with the macro undefined. With SOC_RAM_CTRL_RR_EN and the last grant to p0, p1 is served first.
- Back-to-back:
  - Stimulus: p0 holds req high across four reads, addr 0..3.
  - Response: acks at N+3, N+7, N+11, N+15; each rdata matches memory; no ack is ever asserted on p1.
- Reset mid-access:
  - Stimulus: assert rst_i during CAPTURE of a p1 read.
  - Response: no p1 ack; p1_rdata_o becomes 0; all ram_* strobes 0; the next request starts from IDLE with normal latency.
- Zero byte enable:
  - Stimulus: p1 write with be 2'b00 to a location holding 0x5A5A.
  - Response: ack issued; ram_mask_o 0xFFFF; location still reads 0x5A5A.
